// File: rtl/step_pulse_gen_pkg.sv
// Shared types for the single-step pulse generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package step_pulse_gen_pkg;

  // Debounce FSM states; the encoding is fixed so it can be probed on the bench.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_WT = 2'd1,
    HELD     = 2'd2,
    REL_WT   = 2'd3
  } dbState_t;

  localparam int STEP_CNT_W = 16;

endpackage

// File: rtl/step_pulse_gen_debounce_filter.sv
// Synchronizes and debounces the raw push button; emits a debounced level and a press strobe.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES+1 stable samples before the level changes.
// Backpressure: none; the filter free-runs on every clk.
//
// Ports:
//   clk, reset  : system clock, synchronous active-high reset
//   btnRaw      : raw asynchronous button (1 = pressed)
//   level       : debounced level, high in HELD and REL_WT
//   rise        : combinational strobe, high in the cycle the FSM commits PRESS_WT -> HELD
module debounce_filter
  import step_pulse_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic btnRaw,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             syncMeta;
  logic             syncBtn;
  dbState_t         state;
  dbState_t         stateNext;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] timerNext;

  always_ff @(posedge clk) begin
    if (reset) begin
      syncMeta <= 1'b0;
      syncBtn  <= 1'b0;
      state    <= IDLE;
      timer    <= '0;
    end else begin
      syncMeta <= btnRaw;
      syncBtn  <= syncMeta;
      state    <= stateNext;
      timer    <= timerNext;
    end
  end

  // Any sample that disagrees with the pending level sends the FSM back to
  // the stable state, so only an unbroken run of equal samples commits.
  always_comb begin
    stateNext = state;
    timerNext = timer;
    rise      = 1'b0;
    case (state)
      IDLE: begin
        if (syncBtn) begin
          stateNext = PRESS_WT;
          timerNext = '0;
        end
      end
      PRESS_WT: begin
        if (!syncBtn) begin
          stateNext = IDLE;
          timerNext = '0;
        end else if (timer == LAST) begin
          stateNext = HELD;
          rise      = 1'b1;
        end else begin
          timerNext = timer + 1'b1;
        end
      end
      HELD: begin
        if (!syncBtn) begin
          stateNext = REL_WT;
          timerNext = '0;
        end
      end
      REL_WT: begin
        // Returning to HELD from a release bounce is not a new press: no rise.
        if (syncBtn) begin
          stateNext = HELD;
          timerNext = '0;
        end else if (timer == LAST) begin
          stateNext = IDLE;
        end else begin
          timerNext = timer + 1'b1;
        end
      end
      default: begin
        stateNext = IDLE;
        timerNext = '0;
      end
    endcase
  end

  assign level = (state == HELD) || (state == REL_WT);

endmodule

// File: rtl/step_pulse_gen.sv
// Produces a one-clk step enable from a debounced button press or a free-running rate timer.
// Latency: manual pulse 7+ cycles after the press (2 sync + debounce + 1); auto pulse RUN_DIV cycles apart.
// Backpressure: none; pulses are fire-and-forget.
//
// Ports:
//   clk, reset  : system clock, synchronous active-high reset
//   PushButton  : raw bouncing button (1 = pressed)
//   run_mode    : 1 = auto-step every RUN_DIV cycles, 0 = one step per press
//   step_pulse  : registered one-cycle step enable
//   step_count  : number of step pulses since reset, wraps silently
//   btn_level   : debounced button level
module step_pulse_gen
  import step_pulse_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RUN_DIV         = 50000000,
  parameter int CNT_W           = 26
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  PushButton,
  input  logic                  run_mode,
  output logic                  step_pulse,
  output logic [STEP_CNT_W-1:0] step_count,
  output logic                  btn_level
);

  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_DIV - 1);

  logic             manualRise;
  logic [CNT_W-1:0] runTimer;
  logic             runWrap;

  debounce_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_debounce (
    .clk   (clk),
    .reset (reset),
    .btnRaw(PushButton),
    .level (btn_level),
    .rise  (manualRise)
  );

  // Gating the wrap with run_mode drops a wrap that coincides with run_mode falling.
  assign runWrap = run_mode && (runTimer == RUN_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      runTimer   <= '0;
      step_pulse <= 1'b0;
      step_count <= '0;
    end else begin
      if (!run_mode || runWrap) begin
        runTimer <= '0;
      end else begin
        runTimer <= runTimer + 1'b1;
      end
      step_pulse <= run_mode ? runWrap : manualRise;
      step_count <= step_count + STEP_CNT_W'(step_pulse);
    end
  end

endmodule

// File: tb/tb_step_pulse_gen.sv
module tb_step_pulse_gen;

  localparam int D  = 4;
  localparam int RD = 8;
  localparam int CW = 26;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset      = 1'b1;
  logic        PushButton = 1'b1;
  logic        run_mode   = 1'b0;
  logic        step_pulse;
  logic [15:0] step_count;
  logic        btn_level;

  // Second instance stepping every cycle, used only for the counter wrap.
  logic        reset2     = 1'b1;
  logic        PushButton2 = 1'b0;
  logic        run_mode2  = 1'b1;
  logic        step_pulse2;
  logic [15:0] step_count2;
  logic        btn_level2;

  step_pulse_gen #(.DEBOUNCE_CYCLES(D), .RUN_DIV(RD), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .PushButton(PushButton), .run_mode(run_mode),
    .step_pulse(step_pulse), .step_count(step_count), .btn_level(btn_level)
  );

  step_pulse_gen #(.DEBOUNCE_CYCLES(D), .RUN_DIV(1), .CNT_W(CW)) dut2 (
    .clk(clk), .reset(reset2), .PushButton(PushButton2), .run_mode(run_mode2),
    .step_pulse(step_pulse2), .step_count(step_count2), .btn_level(btn_level2)
  );

  int passCnt  = 0;
  int totalCnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cycle();
    @(negedge clk);
  endtask

  // ---------------- behavioural model ----------------
  // Level follows the synchronized button once it has disagreed with the
  // current level for D+1 consecutive samples; run-mode pulses land on every
  // RD-th cycle of continuous run_mode.
  logic [1:0]  hist   = 2'b00;
  logic        mLevel = 1'b0;
  int          diffRun = 0;
  int          runAge  = 0;
  logic        mPulse = 1'b0;
  logic [15:0] mCount = 16'h0;

  logic nLevel, nManual, nPulse;
  int   nDiff, nAge;

  always @* begin
    nLevel  = mLevel;
    nManual = 1'b0;
    nDiff   = 0;
    if (hist[1] != mLevel) begin
      if (diffRun == D) begin
        nLevel  = hist[1];
        nManual = hist[1];
      end else begin
        nDiff = diffRun + 1;
      end
    end
    nAge   = run_mode ? runAge + 1 : 0;
    nPulse = run_mode ? ((nAge % RD) == 0) : nManual;
  end

  always @(posedge clk) begin
    if (reset) begin
      hist    <= 2'b00;
      mLevel  <= 1'b0;
      diffRun <= 0;
      runAge  <= 0;
      mPulse  <= 1'b0;
      mCount  <= 16'h0;
    end else begin
      hist    <= {hist[0], PushButton};
      mLevel  <= nLevel;
      diffRun <= nDiff;
      runAge  <= nAge;
      mPulse  <= nPulse;
      mCount  <= mCount + 16'(mPulse);
    end
  end

  // ---------------- per-cycle compare ----------------
  logic cmpEn = 1'b1;
  initial begin
    @(negedge clk);
    while (cmpEn) begin
      check("model step_pulse", step_pulse, mPulse);
      check("model step_count", step_count, mCount);
      check("model btn_level",  btn_level,  mLevel);
      @(negedge clk);
    end
  end

  // ---------------- counter wrap on the fast instance ----------------
  logic done2 = 1'b0;
  initial begin
    repeat (2) cycle();
    reset2 = 1'b0;
    cycle();
    check("wrap first pulse", step_pulse2, 1'b1);
    check("wrap first count", step_count2, 16'h0000);
    cycle();
    check("wrap second count", step_count2, 16'h0001);
    repeat (65533) cycle();
    cycle();
    check("wrap count FFFF", step_count2, 16'hFFFF);
    cycle();
    check("wrap count 0000", step_count2, 16'h0000);
    check("wrap pulse", step_pulse2, 1'b1);
    done2 = 1'b1;
  end

  // ---------------- directed tests ----------------
  initial begin
    int pulses;
    int at;
    int bad;

    // 1: reset held with the button pressed
    repeat (2) begin
      cycle();
      check("t1 step_pulse", step_pulse, 1'b0);
      check("t1 step_count", step_count, 16'h0);
      check("t1 btn_level",  btn_level,  1'b0);
    end
    reset = 1'b0;
    PushButton = 1'b0;
    repeat (10) cycle();

    // 2: clean press, pulse 2+4+1 cycles after the rise
    PushButton = 1'b1;
    pulses = 0; at = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      if (step_pulse) begin pulses++; at = i; end
    end
    check("t2 pulse count", pulses, 1);
    check("t2 pulse latency", at, 7);
    check("t2 step_count", step_count, 16'd1);
    check("t2 btn_level held", btn_level, 1'b1);
    PushButton = 1'b0;
    repeat (12) cycle();
    check("t2 btn_level released", btn_level, 1'b0);

    // 3: bouncing shorter than the debounce window
    pulses = 0; bad = 0;
    for (int i = 0; i < 16; i++) begin
      PushButton = ((i / 2) % 2) == 0;
      cycle();
      if (step_pulse) pulses++;
      if (btn_level) bad++;
    end
    PushButton = 1'b0;
    repeat (10) begin
      cycle();
      if (step_pulse) pulses++;
      if (btn_level) bad++;
    end
    check("t3 pulses", pulses, 0);
    check("t3 btn_level highs", bad, 0);
    check("t3 step_count", step_count, 16'd1);

    // 4: run mode for 40 cycles, then off
    run_mode = 1'b1;
    pulses = 0; bad = 0;
    for (int i = 1; i <= 40; i++) begin
      cycle();
      if (step_pulse) begin
        pulses++;
        if ((i % 8) != 0) bad++;
      end
    end
    run_mode = 1'b0;
    check("t4 pulses", pulses, 5);
    check("t4 off-grid pulses", bad, 0);
    pulses = 0;
    repeat (20) begin
      cycle();
      if (step_pulse) pulses++;
    end
    check("t4 pulses after stop", pulses, 0);
    check("t4 step_count", step_count, 16'd6);

    // 6: reset at run-timer value 5
    run_mode = 1'b1;
    repeat (5) cycle();
    reset = 1'b1;
    cycle();
    check("t6 reset step_pulse", step_pulse, 1'b0);
    check("t6 reset step_count", step_count, 16'h0);
    check("t6 reset btn_level",  btn_level,  1'b0);
    reset = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 7; i++) begin
      cycle();
      if (step_pulse) pulses++;
    end
    check("t6 early pulses", pulses, 0);
    cycle();
    check("t6 first pulse", step_pulse, 1'b1);
    cycle();
    check("t6 step_count", step_count, 16'd1);
    run_mode = 1'b0;
    repeat (4) cycle();
    cmpEn = 1'b0;

    for (int k = 0; k < 80000 && !done2; k++) cycle();
    check("wrap instance finished", done2, 1'b1);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
